// File: rtl/riscv_data_mem_responder.sv
// RV32I data-memory responder: captures one load/store request, waits WAIT_STATES cycles,
// performs a byte/half/word access and signals completion with a one-cycle ready pulse.
module riscv_data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        readEnable,
    input  logic        writeEnable,
    input  logic [2:0]  funct3,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        error,
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic [31:0]             mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   idx;
    logic [31:0]             cur_word;
    logic [7:0]              byte_v;
    logic [15:0]             half_v;
    logic                    access_err;
    logic [31:0]             load_val;
    logic                    mem_we;
    logic [31:0]             mem_wdata;

    // Address bits above the word index are intentionally ignored (address wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[31:ADDR_WIDTH+2];

    always_comb begin
        idx        = addr_q[ADDR_WIDTH+1:2];
        cur_word   = mem_q[idx];
        byte_v     = cur_word[{addr_q[1:0], 3'b000} +: 8];
        half_v     = cur_word[{addr_q[1], 4'b0000} +: 16];
        access_err = 1'b0;
        load_val   = '0;
        mem_wdata  = cur_word;
        case (funct3_q)
            3'b000: begin
                load_val = {{24{byte_v[7]}}, byte_v};
                mem_wdata[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            3'b001: begin
                access_err = addr_q[0];
                load_val   = {{16{half_v[15]}}, half_v};
                mem_wdata[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            3'b010: begin
                access_err = (addr_q[1:0] != 2'b00);
                load_val   = cur_word;
                mem_wdata  = wdata_q;
            end
            3'b100: load_val = {24'h0, byte_v};
            3'b101: begin
                access_err = addr_q[0];
                load_val   = {16'h0, half_v};
            end
            default: access_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (readEnable || writeEnable) begin
                    addr_d   = address[ADDR_WIDTH+1:0];
                    funct3_d = funct3;
                    wdata_d  = writeData;
                    write_d  = writeEnable;
                    cnt_d    = CW'(WAIT_STATES);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    err_d   = access_err;
                    if (write_q) begin
                        mem_we = !access_err;
                    end else begin
                        rdata_d = access_err ? '0 : load_val;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Reset takes priority, so a store pending in WAIT is dropped along with the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (mem_we) begin
            mem_q[idx] <= mem_wdata;
        end
    end

    assign readData = rdata_q;
    assign ready    = (state_q == S_DONE);
    assign error    = (state_q == S_DONE) && err_q;
    assign busy     = (state_q == S_WAIT);

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Directed bench for riscv_data_mem_responder: a vector table on a WAIT_STATES=2 instance
// plus hand sequences for latency, mid-operation reset and a zero-wait-state instance.
module tb_riscv_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] address = '0, writeData = '0, readData;
    logic        readEnable = 1'b0, writeEnable = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        ready, error, busy;

    logic [31:0] address_z = '0, writeData_z = '0, readData_z;
    logic        readEnable_z = 1'b0, writeEnable_z = 1'b0;
    logic [2:0]  funct3_z = '0;
    logic        ready_z, error_z, busy_z;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    riscv_data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .address(address), .readEnable(readEnable),
        .writeEnable(writeEnable), .funct3(funct3), .writeData(writeData),
        .readData(readData), .ready(ready), .error(error), .busy(busy)
    );

    riscv_data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst), .address(address_z), .readEnable(readEnable_z),
        .writeEnable(writeEnable_z), .funct3(funct3_z), .writeData(writeData_z),
        .readData(readData_z), .ready(ready_z), .error(error_z), .busy(busy_z)
    );

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input int sel, input logic we, input logic re, input logic [31:0] a,
                         input logic [2:0] f3, input logic [31:0] wd);
        if (sel == 0) begin
            writeEnable = we; readEnable = re; address = a; funct3 = f3; writeData = wd;
        end else begin
            writeEnable_z = we; readEnable_z = re; address_z = a; funct3_z = f3; writeData_z = wd;
        end
    endtask

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? ready : ready_z;
    endfunction

    // Present a request in an IDLE cycle, count edges from capture to ready, then drop it.
    task automatic req(input int sel, input logic we, input logic re, input logic [31:0] a,
                       input logic [2:0] f3, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat,
                       output logic rdy_after);
        drive(sel, we, re, a, f3, wd);
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rdy_of(sel) && lat < 40);
        rd = (sel == 0) ? readData : readData_z;
        e  = (sel == 0) ? error : error_z;
        drive(sel, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        rdy_after = rdy_of(sel);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        ra;
        int          lat;
        logic        saw_ready;

        vecs.push_back('{1'b1, 1'b0, 32'h10,   3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h13,   3'b000, 32'h0,        32'hFFFFFFDE, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h13,   3'b100, 32'h0,        32'h000000DE, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h12,   3'b001, 32'h0,        32'hFFFFDEAD, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   3'b101, 32'h0,        32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h11,   3'b000, 32'hAAAAAA55, 32'h0000BEEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h12,   3'b010, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h11,   3'b001, 32'h0000FFFF, 32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   3'b010, 32'h0,        32'hDEAD55EF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   3'b011, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h10,   3'b000, 32'h0,        32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h1000, 3'b010, 32'h11223344, 32'hFFFFFFEF, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,    3'b010, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h4,    3'b010, 32'hCAFEF00D, 32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    3'b010, 32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h6,    3'b001, 32'h0,        32'hFFFFCAFE, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h4,    3'b110, 32'h55555555, 32'hFFFFCAFE, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    3'b010, 32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h6,    3'b001, 32'h00001234, 32'hCAFEF00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    3'b010, 32'h0,        32'h1234F00D, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h3,    3'b101, 32'h0,        32'h00000000, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'hFFF,  3'b100, 32'h0,        32'h00000000, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h4,    3'b010, 32'h0,        32'h1234F00D, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset readData", readData, 32'h0);
        chk("reset ready", {31'h0, ready}, 32'h0);
        chk("reset error", {31'h0, error}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);

        // First load: exact cycle-by-cycle busy/ready timing.
        drive(0, 1'b0, 1'b1, 32'h0, 3'b010, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("lw0 busy N+1", {31'h0, busy}, 32'h1);
        chk("lw0 ready N+1", {31'h0, ready}, 32'h0);
        @(posedge clk); #1;
        chk("lw0 busy N+2", {31'h0, busy}, 32'h1);
        chk("lw0 ready N+2", {31'h0, ready}, 32'h0);
        @(posedge clk); #1;
        chk("lw0 ready N+3", {31'h0, ready}, 32'h1);
        chk("lw0 busy N+3", {31'h0, busy}, 32'h0);
        chk("lw0 readData", readData, 32'h0);
        chk("lw0 error", {31'h0, error}, 32'h0);
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        @(posedge clk); #1;
        chk("lw0 ready N+4", {31'h0, ready}, 32'h0);

        foreach (vecs[i]) begin
            req(0, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].f3, vecs[i].wd, rd, e, lat, ra);
            chk($sformatf("row%0d readData", i), rd, vecs[i].exp_rd);
            chk($sformatf("row%0d error", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
            chk($sformatf("row%0d latency", i), lat, 32'd3);
            chk($sformatf("row%0d ready pulse width", i), {31'h0, ra}, 32'h0);
        end

        // Reset while a store sits in WAIT.
        drive(0, 1'b1, 1'b0, 32'h20, 3'b010, 32'h12345678);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort ready", {31'h0, ready}, 32'h0);
        chk("abort readData", readData, 32'h0);
        saw_ready = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready) saw_ready = 1'b1;
        end
        chk("abort no ready pulse", {31'h0, saw_ready}, 32'h0);
        req(0, 1'b0, 1'b1, 32'h20, 3'b010, 32'h0, rd, e, lat, ra);
        chk("abort lw 0x20", rd, 32'h0);
        chk("abort lw 0x20 latency", lat, 32'd3);
        req(0, 1'b0, 1'b1, 32'h4, 3'b010, 32'h0, rd, e, lat, ra);
        chk("reset cleared 0x4", rd, 32'h0);

        // Zero wait states: ready one cycle after capture.
        req(1, 1'b1, 1'b0, 32'h8, 3'b010, 32'hA5A5A5A5, rd, e, lat, ra);
        chk("ws0 sw latency", lat, 32'd1);
        chk("ws0 sw ready pulse width", {31'h0, ra}, 32'h0);
        req(1, 1'b0, 1'b1, 32'h8, 3'b010, 32'h0, rd, e, lat, ra);
        chk("ws0 lw data", rd, 32'hA5A5A5A5);
        chk("ws0 lw latency", lat, 32'd1);
        req(1, 1'b0, 1'b1, 32'h9, 3'b100, 32'h0, rd, e, lat, ra);
        chk("ws0 lbu data", rd, 32'h000000A5);
        req(1, 1'b0, 1'b1, 32'hA, 3'b010, 32'h0, rd, e, lat, ra);
        chk("ws0 misaligned lw error", {31'h0, e}, 32'h1);
        chk("ws0 misaligned lw data", rd, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
